int_controller: RTL and testbench

- Interrupt source side of the processor's INT line. Collects edge-triggered requests from NSRC peripherals and latches them as pending.
- Arbitrates by fixed priority: the lowest index wins.
- Raises INT toward the control unit and holds it until the CU acknowledges.
- Tracks the service window until end-of-interrupt. Sits beside control_unit at the top level and drives its INT input.

---
 rtl/int_controller.sv | 111 +++++++++++
 tb/tb_int_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// rtl/int_controller.sv - edge-latched fixed-priority interrupt source for the CU INT line
// Optional source masking is enabled by defining INT_MASK_EN.
module int_controller #(
    parameter int NSRC  = 4,
    parameter int VEC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NSRC-1:0]  irq_src,
    input  logic             int_ack,
    input  logic             int_eoi,
`ifdef INT_MASK_EN
    input  logic             mask_wr,
    input  logic [NSRC-1:0]  mask_din,
    output logic [NSRC-1:0]  int_mask,
`endif
    output logic             INT,
    output logic [VEC_W-1:0] int_vec,
    output logic             int_active,
    output logic [NSRC-1:0]  pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NSRC-1:0]  irq_prev;
    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  clr;
    logic [NSRC-1:0]  eligible;
    logic [VEC_W-1:0] lowest;
    logic [VEC_W-1:0] vec_nxt;

    assign rise = irq_src & ~irq_prev;

`ifdef INT_MASK_EN
    // Masking only gates arbitration; requests keep latching into pending.
    assign eligible = pending & int_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_mask <= '1;
        end else if (mask_wr) begin
            int_mask <= mask_din;
        end
    end
`else
    assign eligible = pending;
`endif

    always_comb begin
        lowest = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = int_vec;
        clr       = '0;
        case (state)
            S_IDLE: begin
                if (|eligible) begin
                    state_nxt = S_ASSERT;
                    vec_nxt   = lowest;
                end
            end
            S_ASSERT: begin
                if (int_ack) begin
                    state_nxt    = S_SERVICE;
                    clr[int_vec] = 1'b1;
                end
            end
            S_SERVICE: begin
                if (int_eoi) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            INT        <= 1'b0;
            int_vec    <= '0;
            int_active <= 1'b0;
            pending    <= '0;
            irq_prev   <= '0;
        end else begin
            state      <= state_nxt;
            INT        <= (state_nxt == S_ASSERT);
            int_active <= (state_nxt == S_SERVICE);
            int_vec    <= vec_nxt;
            // OR-ing rise last lets a fresh edge survive a same-cycle clear.
            pending    <= (pending & ~clr) | rise;
            irq_prev   <= irq_src;
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - randomized and directed checks of int_controller against a behavioural model
module tb_int_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_src = 4'b0000;
    logic       int_ack = 1'b0;
    logic       int_eoi = 1'b0;
    logic       INT;
    logic [1:0] int_vec;
    logic       int_active;
    logic [3:0] pending;
`ifdef INT_MASK_EN
    logic       mask_wr = 1'b0;
    logic [3:0] mask_din = 4'b1111;
    logic [3:0] int_mask;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: service phase tracked as two flags, pending as a plain set.
    logic [3:0] m_pending = '0;
    logic [3:0] m_prev = '0;
    logic [3:0] m_mask = 4'b1111;
    logic       m_int = 1'b0;
    logic       m_active = 1'b0;
    int         m_vec = 0;

    int_controller #(.NSRC(4), .VEC_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi),
`ifdef INT_MASK_EN
        .mask_wr    (mask_wr),
        .mask_din   (mask_din),
        .int_mask   (int_mask),
`endif
        .INT        (INT),
        .int_vec    (int_vec),
        .int_active (int_active),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    function automatic int first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [3:0] rise;
        logic [3:0] clr;
        logic [3:0] elig;
        if (!rst_n) begin
            m_pending = '0;
            m_prev    = '0;
            m_int     = 1'b0;
            m_active  = 1'b0;
            m_vec     = 0;
            m_mask    = 4'b1111;
        end else begin
            rise = irq_src & ~m_prev;
            clr  = '0;
            elig = m_pending & m_mask;
            if (m_int) begin
                if (int_ack) begin
                    m_int     = 1'b0;
                    m_active  = 1'b1;
                    clr[m_vec] = 1'b1;
                end
            end else if (m_active) begin
                if (int_eoi) m_active = 1'b0;
            end else if (elig != 0) begin
                m_int = 1'b1;
                m_vec = first_set(elig);
            end
            m_pending = (m_pending & ~clr) | rise;
            m_prev    = irq_src;
`ifdef INT_MASK_EN
            if (mask_wr) m_mask = mask_din;
`endif
        end
    endtask

    task automatic tick(input logic [3:0] src, input logic ack, input logic eoi, input logic rn);
        irq_src = src;
        int_ack = ack;
        int_eoi = eoi;
        rst_n   = rn;
        @(posedge clk);
        model_step();
        #1;
        chk("INT", 32'(INT), 32'(m_int));
        chk("int_vec", 32'(int_vec), 32'(m_vec));
        chk("int_active", 32'(int_active), 32'(m_active));
        chk("pending", 32'(pending), 32'(m_pending));
`ifdef INT_MASK_EN
        chk("int_mask", 32'(int_mask), 32'(m_mask));
        mask_wr = 1'b0;
`endif
    endtask

    initial begin
        // reset hold, then a single request on source 2
        for (int i = 0; i < 3; i++) tick(4'b0000, 0, 0, 0);
        chk("reset_outputs", {INT, int_active, int_vec, pending}, 32'h0);
        tick(4'b0100, 0, 0, 1);
        chk("pend_after_pulse", 32'(pending), 32'h4);
        chk("int_not_yet", 32'(INT), 32'h0);
        tick(4'b0000, 0, 0, 1);
        chk("int_raised", 32'({INT, int_vec}), 32'h6);
        tick(4'b0000, 1, 0, 1);
        chk("ack_service", 32'({INT, int_active, pending}), 32'h10);
        tick(4'b0000, 0, 1, 1);
        chk("eoi_idle", 32'({INT, int_active}), 32'h0);

        // simultaneous 3 and 1: 1 first, one idle cycle, then 3
        tick(4'b1010, 0, 0, 1);
        tick(4'b1010, 0, 0, 1);
        chk("prio_vec1", 32'({INT, int_vec}), 32'h5);
        tick(4'b0000, 1, 0, 1);
        chk("pend_left_3", 32'(pending), 32'h8);
        tick(4'b0000, 0, 1, 1);
        chk("gap_idle", 32'(INT), 32'h0);
        tick(4'b0000, 0, 0, 1);
        chk("prio_vec3", 32'({INT, int_vec}), 32'h7);
        tick(4'b0000, 1, 0, 1);
        tick(4'b0000, 0, 1, 1);

        // vector frozen in ASSERT; set wins over clear
        tick(4'b0100, 0, 0, 1);
        tick(4'b0000, 0, 0, 1);
        tick(4'b0001, 0, 0, 1);
        chk("vec_frozen", 32'(int_vec), 32'h2);
        tick(4'b0000, 1, 0, 1);
        chk("pend_after_ack", 32'(pending), 32'h1);
        tick(4'b0000, 0, 1, 1);
        tick(4'b0000, 0, 0, 1);
        chk("vec0_raised", 32'({INT, int_vec}), 32'h4);
        tick(4'b0001, 1, 0, 1);
        chk("set_wins", 32'(pending), 32'h1);
        tick(4'b0000, 0, 1, 1);
        tick(4'b0000, 0, 0, 1);
        tick(4'b0000, 1, 0, 1);
        tick(4'b0000, 0, 1, 1);

        // ignored ack/eoi, long unacked INT
        tick(4'b0000, 1, 0, 1);
        chk("ack_in_idle", 32'({INT, int_active}), 32'h0);
        tick(4'b0100, 0, 0, 1);
        tick(4'b0000, 0, 0, 1);
        tick(4'b0000, 0, 1, 1);
        chk("eoi_in_assert", 32'({INT, int_active}), 32'h2);
        for (int i = 0; i < 20; i++) tick(4'b0000, 0, 0, 1);
        chk("int_held", 32'({INT, int_vec}), 32'h6);
        tick(4'b0000, 1, 1, 1);
        chk("ack_beats_eoi", 32'(int_active), 32'h1);

        // reset during service, source 1 held across reset
        tick(4'b1000, 0, 0, 1);
        chk("pend_in_service", 32'(pending), 32'h8);
        tick(4'b0010, 0, 0, 0);
        chk("reset_mid_service", {INT, int_active, int_vec, pending}, 32'h0);
        tick(4'b0010, 0, 0, 1);
        chk("held_one_req", 32'(pending), 32'h2);
        tick(4'b0010, 0, 0, 1);
        tick(4'b0010, 1, 0, 1);
        tick(4'b0010, 0, 1, 1);
        for (int i = 0; i < 3; i++) tick(4'b0010, 0, 0, 1);
        chk("no_retrigger", 32'({INT, pending}), 32'h0);
        tick(4'b0000, 0, 0, 1);

`ifdef INT_MASK_EN
        mask_wr = 1'b1; mask_din = 4'b1110;
        tick(4'b0000, 0, 0, 1);
        tick(4'b0001, 0, 0, 1);
        tick(4'b0000, 0, 0, 1);
        tick(4'b0000, 0, 0, 1);
        chk("masked_pending", 32'({INT, pending}), 32'h1);
        mask_wr = 1'b1; mask_din = 4'b1111;
        tick(4'b0000, 0, 0, 1);
        tick(4'b0000, 0, 0, 1);
        chk("unmasked_fires", 32'({INT, int_vec}), 32'h4);
        tick(4'b0000, 1, 0, 1);
        tick(4'b0000, 0, 1, 1);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
`ifdef INT_MASK_EN
            mask_wr  = ($urandom_range(0, 9) == 0);
            mask_din = 4'($urandom);
`endif
            tick(4'($urandom) & 4'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 49) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
